// File: rtl/sram_arbiter.sv
// Two-port arbiter for one 1Mx16 async SRAM. It runs one whole-word access at a time with a fixed strobe window.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate grants under contention. The default build uses fixed cpu-first priority.

module sram_arbiter #(
  parameter int         WAIT_CYCLES = 2,
  parameter logic [3:0] ADDR_HI     = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic [15:0] ld_rdata,
  output logic        ld_done,
  output logic        owner,
  output logic        busy,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it until its done pulse.
  // The request is sampled only in IDLE. done is a single cycle, and rdata stays valid after it.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        grant;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Under contention the port that did not win last time gets the grant.
  assign grant = (cpu_req && ld_req) ? ~owner : ~cpu_req;
`else
  assign grant = ~cpu_req;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cpu_req || ld_req) state_nx = S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: if (wait_cnt == 4'd0) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      owner     <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ADDR      <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: if (cpu_req || ld_req) begin
          owner   <= grant;
          we_q    <= grant ? ld_we : cpu_we;
          wdata_q <= grant ? ld_wdata : cpu_wdata;
          ADDR    <= {ADDR_HI, (grant ? ld_addr : cpu_addr)};
        end
        S_SETUP: wait_cnt <= 4'(WAIT_CYCLES - 1);
        S_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            // Read data is sampled on the last edge of the strobe window.
            if (!we_q && !owner) cpu_rdata <= Data_from_SRAM;
            if (!we_q && owner)  ld_rdata  <= Data_from_SRAM;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    CE           = 1'b1;
    UB           = 1'b1;
    LB           = 1'b1;
    OE           = 1'b1;
    WE           = 1'b1;
    Data_to_SRAM = '0;
    cpu_done     = 1'b0;
    ld_done      = 1'b0;
    case (state)
      S_SETUP: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        OE = we_q;
      end
      S_ACCESS: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        OE = we_q;
        WE = ~we_q;
        if (we_q) Data_to_SRAM = wdata_q;
      end
      S_DONE: begin
        cpu_done = ~owner;
        ld_done  = owner;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter. It drives a table of single transactions plus hand-written corner sequences.
// A scoreboard queue tracks expected read data, alongside a small SRAM model and a strobe monitor.

module tb_sram_arbiter;

  localparam int W0 = 2;
  localparam int W1 = 1;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  // ---------------- DUT 0 (WAIT_CYCLES=2) ----------------
  logic        cpu_req, cpu_we, cpu_done, ld_req, ld_we, ld_done;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, ld_addr, ld_wdata, ld_rdata;
  logic        owner, busy, CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;

  sram_arbiter #(.WAIT_CYCLES(W0), .ADDR_HI(4'h0)) u0 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .owner(owner), .busy(busy), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM)
  );

  // ---------------- DUT 1 (WAIT_CYCLES=1, ADDR_HI=A) ----------------
  logic        c1_cpu_req, c1_cpu_we, c1_cpu_done, c1_ld_req, c1_ld_we, c1_ld_done;
  logic [15:0] c1_cpu_addr, c1_cpu_wdata, c1_cpu_rdata, c1_ld_addr, c1_ld_wdata, c1_ld_rdata;
  logic        c1_owner, c1_busy, c1_ce, c1_ub, c1_lb, c1_oe, c1_we;
  logic [19:0] c1_addr;
  logic [15:0] c1_dout, c1_din;

  sram_arbiter #(.WAIT_CYCLES(W1), .ADDR_HI(4'hA)) u1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(c1_cpu_req), .cpu_we(c1_cpu_we), .cpu_addr(c1_cpu_addr), .cpu_wdata(c1_cpu_wdata),
    .cpu_rdata(c1_cpu_rdata), .cpu_done(c1_cpu_done),
    .ld_req(c1_ld_req), .ld_we(c1_ld_we), .ld_addr(c1_ld_addr), .ld_wdata(c1_ld_wdata),
    .ld_rdata(c1_ld_rdata), .ld_done(c1_ld_done),
    .owner(c1_owner), .busy(c1_busy), .CE(c1_ce), .UB(c1_ub), .LB(c1_lb), .OE(c1_oe), .WE(c1_we),
    .ADDR(c1_addr), .Data_to_SRAM(c1_dout), .Data_from_SRAM(c1_din)
  );

  // ---------------- SRAM models ----------------
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0042) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  logic [15:0] mem0 [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem0[i] = init_val(16'(i));
    forever begin
      @(posedge Clk);
      if (!CE && !WE) mem0[ADDR[15:0]] = Data_to_SRAM;
    end
  end
  assign Data_from_SRAM = (!CE && !OE) ? mem0[ADDR[15:0]] : 16'h0;
  assign c1_din         = (!c1_ce && !c1_oe) ? init_val(c1_addr[15:0]) : 16'h0;

  // ---------------- strobe monitor ----------------
  int          tot_rd = 0, tot_wr = 0, tot_cd = 0, tot_ld = 0, bad_wd = 0, inv_bad = 0;
  logic [19:0] last_addr = '0, last_addr1 = '0;
  logic [15:0] cur_wdata_exp = '0;

  always @(negedge Clk) begin
    if (!CE && !OE) tot_rd <= tot_rd + 1;
    if (!CE && !WE) begin
      tot_wr <= tot_wr + 1;
      if (Data_to_SRAM !== cur_wdata_exp || OE !== 1'b1) bad_wd <= bad_wd + 1;
    end
    if (!CE) last_addr <= ADDR;
    if (!c1_ce) last_addr1 <= c1_addr;
    if (cpu_done) tot_cd <= tot_cd + 1;
    if (ld_done)  tot_ld <= tot_ld + 1;
    if ((!CE && (UB || LB)) || (WE && Data_to_SRAM != 16'h0) || (!OE && !WE) || (cpu_done && ld_done))
      inv_bad <= inv_bad + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0, n_miss = 0;
  logic [16:0] exp_q[$];
  logic [15:0] exp_mem [logic [15:0]];
  logic [15:0] last_rd [2];

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [16:0] act);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic do_txn(input vec_t v);
    int   n, s_rd, s_wr, s_bwd;
    logic got;
    exp_q.push_back({v.port, v.exp_rdata});
    cur_wdata_exp = v.wdata;
    s_rd = tot_rd; s_wr = tot_wr; s_bwd = bad_wd;
    @(posedge Clk); #1;
    if (v.port) begin
      ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata; ld_req = 1'b1;
    end else begin
      cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge Clk); @(negedge Clk);
      n++;
      got = cpu_done | ld_done;
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL txn_timeout: no done within %0d cycles (addr 0x%0h)", n, v.addr);
      void'(exp_q.pop_back());
    end else begin
      check("latency", 32'(n), 32'(W0 + 2));
      check("done_pair", 32'({cpu_done, ld_done}), v.port ? 32'h1 : 32'h2);
      check("owner", 32'(owner), 32'(v.port));
      sb_check("rdata", {ld_done, (ld_done ? ld_rdata : cpu_rdata)});
      @(posedge Clk); @(negedge Clk);
      check("done_width", 32'({cpu_done, ld_done, busy}), 32'h0);
      check("addr", 32'(last_addr), 32'({4'h0, v.addr}));
      check("oe_cycles", 32'(tot_rd - s_rd), v.we ? 32'd0 : 32'(W0 + 1));
      check("we_cycles", 32'(tot_wr - s_wr), v.we ? 32'(W0) : 32'd0);
      check("wdata_bus", 32'(bad_wd - s_bwd), 32'h0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int          n, k, d, first, s_cd, s_rd, s_ld;
    int          t [2];
    logic [15:0] e;
    logic [3:0]  own_seq;

    Reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    c1_cpu_req = 0; c1_cpu_we = 0; c1_cpu_addr = '0; c1_cpu_wdata = '0;
    c1_ld_req = 0; c1_ld_we = 0; c1_ld_addr = '0; c1_ld_wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    t[0] = 0; t[1] = 0;

    repeat (3) @(negedge Clk);
    check("rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    check("rst_addr", 32'(ADDR), 32'h0);
    check("rst_wdata", 32'(Data_to_SRAM), 32'h0);
    check("rst_rdata", {cpu_rdata, ld_rdata}, 32'h0);
    check("rst_flags", 32'({cpu_done, ld_done, owner, busy}), 32'h0);
    check("rst_u1_strobes", 32'({c1_ce, c1_oe, c1_we, c1_busy}), 32'hE);
    Reset = 1'b1;

    // port, we, addr, wdata, expected rdata after done
    vecs[0] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'hA5A5, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 16'hA5A5};
    vecs[3] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 16'h1111, 16'h1357, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b0, 16'h1111, 16'h0000, 16'h1357};
    vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 16'hA5A5};
    vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F};
    vecs[8] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h5A59};
    for (int i = 9; i < 15; i++) begin
      vecs[i].port  = 1'($urandom_range(0, 1));
      vecs[i].we    = 1'($urandom_range(0, 1));
      vecs[i].addr  = 16'($urandom_range(0, 15));
      vecs[i].wdata = 16'($urandom_range(0, 65535));
    end
    for (int i = 0; i < 15; i++) begin
      if (i >= 9) vecs[i].exp_rdata = vecs[i].we ? last_rd[vecs[i].port] : exp_rd(vecs[i].addr);
      if (vecs[i].we) exp_mem[vecs[i].addr] = vecs[i].wdata;
      else            last_rd[vecs[i].port] = vecs[i].exp_rdata;
    end
    for (int i = 0; i < 15; i++) do_txn(vecs[i]);

    // single-cycle request pulse still completes exactly one access
    e = exp_rd(16'h0010);
    exp_q.push_back({1'b0, e});
    s_cd = tot_cd; s_rd = tot_rd; first = -1;
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    @(posedge Clk); #1;
    cpu_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (cpu_done && first < 0) begin
        first = i;
        sb_check("pulse_rdata", {ld_done, cpu_rdata});
      end
      @(posedge Clk);
    end
    #1;
    check("pulse_latency", 32'(first), 32'(W0 + 2));
    check("pulse_done_count", 32'(tot_cd - s_cd), 32'd1);
    check("pulse_single_access", 32'(tot_rd - s_rd), 32'(W0 + 1));
    check("pulse_rdata_held", 32'(cpu_rdata), 32'(e));
    check("pulse_idle", 32'(busy), 32'h0);

    // asynchronous reset in the middle of a write
    cur_wdata_exp = 16'h5555;
    s_cd = tot_cd;
    @(posedge Clk); #1;
    cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'h5555; cpu_req = 1'b1;
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    check("pre_reset_access", 32'({CE, WE, OE}), 32'h1);
    #1 Reset = 1'b0;
    #1;
    check("mid_reset_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    check("mid_reset_busy_addr", 32'({busy, ADDR}), 32'h0);
    check("mid_reset_data", {Data_to_SRAM, cpu_rdata}, 32'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge Clk); @(posedge Clk); #1 Reset = 1'b1;
    repeat (10) @(negedge Clk);
    check("mid_reset_no_done", 32'(tot_cd - s_cd), 32'h0);
    check("mid_reset_idle", 32'({busy, owner}), 32'h0);

    // both ports requesting continuously for four transactions
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    own_seq = 4'b0101;
`else
    own_seq = 4'b0000;
`endif
    cpu_we = 1'b0; ld_we = 1'b0; cpu_addr = 16'h0100; ld_addr = 16'h0200;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({own_seq[i], (own_seq[i] ? exp_rd(16'h0200) : exp_rd(16'h0100))});
    s_ld = tot_ld;
    @(posedge Clk); #1;
    cpu_req = 1'b1; ld_req = 1'b1;
    n = 0; k = 0;
    while (k < 4 && n < 80) begin
      @(posedge Clk); @(negedge Clk);
      n++;
      if (cpu_done || ld_done) begin
        check("contend_owner", 32'(owner), 32'(own_seq[k]));
        sb_check("contend_rdata", {ld_done, (ld_done ? ld_rdata : cpu_rdata)});
        k++;
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    check("contend_count", 32'(k), 32'd4);
    repeat (3) @(negedge Clk);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    check("contend_ld_done", 32'(tot_ld - s_ld), 32'd2);
`else
    check("contend_ld_done", 32'(tot_ld - s_ld), 32'd0);
`endif
    while (exp_q.size() > k) void'(exp_q.pop_back());

    // WAIT_CYCLES=1: back-to-back reads with req held through done
    exp_q.push_back({1'b0, init_val(16'h0001)});
    exp_q.push_back({1'b0, init_val(16'h0002)});
    @(posedge Clk); #1;
    c1_cpu_we = 1'b0; c1_cpu_addr = 16'h0001; c1_cpu_req = 1'b1;
    n = 0; d = 0;
    while (d < 2 && n < 40) begin
      @(posedge Clk); @(negedge Clk);
      n++;
      if (c1_cpu_done) begin
        t[d] = n;
        sb_check("b2b_rdata", {c1_ld_done, c1_cpu_rdata});
        d++;
        c1_cpu_addr = 16'h0002;
      end
    end
    c1_cpu_req = 1'b0;
    check("b2b_count", 32'(d), 32'd2);
    check("b2b_first_latency", 32'(t[0]), 32'(W1 + 2));
    check("b2b_gap", 32'(t[1] - t[0]), 32'd4);
    check("b2b_addr_hi", 32'(last_addr1), 32'hA0002);
    repeat (4) @(negedge Clk);
    check("b2b_rdata_held", 32'(c1_cpu_rdata), 32'(init_val(16'h0002)));
    check("b2b_idle", 32'({c1_busy, c1_ld_done}), 32'h0);

    repeat (2) @(negedge Clk);
    check("invariants", 32'(inv_bad), 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
